// File: rtl/prog_loader.sv
// Boot-time program loader: accepts a framed byte stream (LEN, LEN data bytes,
// CSUM) over valid/ready, writes the data bytes into the CPU memory from
// address 0 upward, verifies a modulo-256 checksum and releases the CPU reset
// only after a good load. Optional feature macro: LOADER_ZERO_FILL_EN, which
// zero-fills addresses LEN..DEPTH-1 after a good checksum before done rises.
module prog_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

`ifdef LOADER_ZERO_FILL_EN
    typedef enum logic [2:0] {
        ST_WAIT_LEN, ST_LOAD, ST_WAIT_CSUM, ST_DONE, ST_ERR, ST_FILL
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_WAIT_LEN, ST_LOAD, ST_WAIT_CSUM, ST_DONE, ST_ERR
    } state_t;
`endif

    // Counters are one bit wider than the address so a full-depth LEN fits.
    localparam logic [ADDR_W:0]   DEPTH_CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [DATA_W-1:0] DEPTH_BYTE = DATA_W'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                crst_q, crst_d;
    logic                accept;

    assign in_ready  = (state_q == ST_WAIT_LEN) || (state_q == ST_LOAD) ||
                       (state_q == ST_WAIT_CSUM);
    assign accept    = in_valid & in_ready;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_reset = crst_q;
    assign done      = done_q;
    assign error     = error_q;

    // State and registered outputs; reset raises cpu_reset asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_WAIT_LEN;
            len_q   <= '0;
            count_q <= '0;
            sum_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            crst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            error_q <= error_d;
            crst_q  <= crst_d;
        end
    end

    // Frame parser: next state, write strobe/address/data and status flags.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (clear) begin
            state_d = ST_WAIT_LEN;
            count_d = '0;
            sum_d   = '0;
        end else begin
            case (state_q)
                ST_WAIT_LEN: begin
                    if (accept) begin
                        if (in_data == '0 || in_data > DEPTH_BYTE) begin
                            state_d = ST_ERR;
                        end else begin
                            len_d   = in_data[ADDR_W:0];
                            count_d = '0;
                            sum_d   = '0;
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        we_d    = 1'b1;
                        addr_d  = count_q[ADDR_W-1:0];
                        wdata_d = in_data;
                        sum_d   = sum_q + in_data;
                        count_d = count_q + 1'b1;
                        if (count_q + 1'b1 == len_q) begin
                            state_d = ST_WAIT_CSUM;
                        end
                    end
                end
                ST_WAIT_CSUM: begin
                    if (accept) begin
                        if (in_data != sum_q) begin
                            state_d = ST_ERR;
                        end else begin
`ifdef LOADER_ZERO_FILL_EN
                            // count already equals LEN, so it doubles as the fill pointer.
                            state_d = (len_q == DEPTH_CNT) ? ST_DONE : ST_FILL;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end
                end
`ifdef LOADER_ZERO_FILL_EN
                ST_FILL: begin
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    wdata_d = '0;
                    count_d = count_q + 1'b1;
                    if (count_q == DEPTH_CNT - 1'b1) begin
                        state_d = ST_DONE;
                    end
                end
`endif
                default: ;
            endcase
        end

        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERR);
        crst_d  = (state_d != ST_DONE);
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed vector table, hand-written boundary/reset
// sequences, and random frames checked against a frame-level reference.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, mem_we, cpu_reset, done, error;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;

    prog_loader #(.DEPTH(32), .ADDR_W(5), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    // Every write the memory would see, captured mid-cycle.
    logic [12:0] obs_q[$];
    always @(negedge clk) begin
        if (!reset && mem_we) obs_q.push_back({mem_addr, mem_wdata});
    end

    int unsigned obs_base = 0;
    logic [12:0] exp_w[$];

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       c;
        logic       rdy;
        logic       we;
        logic [4:0] a;
        logic [7:0] wd;
        logic       crst;
        logic       dn;
        logic       er;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [17:0] pack(input logic rdy, input logic we,
                                         input logic [4:0] a, input logic [7:0] wd,
                                         input logic crst, input logic dn, input logic er);
        return {rdy, we, (we ? a : 5'd0), (we ? wd : 8'd0), crst, dn, er};
    endfunction

    task automatic check_vec(input string name, input logic [17:0] exp);
        logic [17:0] act;
        act = pack(in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got rdy/we/addr/wdata/crst/done/err=%h expected %h", name, act, exp);
    endtask

    task automatic check_writes(input string name);
        int unsigned n;
        int bad;
        bit ok;
        n = obs_q.size() - obs_base;
        bad = -1;
        ok = (n == exp_w.size());
        if (ok) begin
            for (int unsigned i = 0; i < n; i++) begin
                if (obs_q[obs_base + i] !== exp_w[i]) begin
                    ok = 1'b0;
                    if (bad < 0) bad = int'(i);
                end
            end
        end
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0d writes (first wrong index %0d), expected %0d writes",
                      name, n, bad, exp_w.size());
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        bit acc;
        int unsigned n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            clear    = 1'b0;
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            total_cnt++;
            $display("FAIL send_byte: byte %h not accepted within 20 cycles", d);
        end
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) step(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic begin_frame();
        step(1'b0, 8'h00, 1'b1);
        obs_base = obs_q.size();
        exp_w.delete();
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic c,
                       input logic rdy, input logic we, input logic [4:0] a,
                       input logic [7:0] wd, input logic crst, input logic dn,
                       input logic er);
        vec_t e;
        e.v = v; e.d = d; e.c = c; e.rdy = rdy; e.we = we; e.a = a; e.wd = wd;
        e.crst = crst; e.dn = dn; e.er = er;
        tbl.push_back(e);
    endtask

    // Frame-level reference: writes are data[i] at address i, outcome from sums.
    task automatic random_frame(input int unsigned idx);
        int unsigned kind, len, k;
        logic [7:0] data, sum, csum;
        bit good;
        begin_frame();
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
            len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 255);
            send_byte(8'(len));
            check_vec($sformatf("rnd%0d_badlen", idx), pack(0, 0, 0, 0, 1, 0, 1));
            check_writes($sformatf("rnd%0d_badlen_writes", idx));
            return;
        end
        len = $urandom_range(1, 32);
        k = (kind == 1) ? $urandom_range(0, len - 1) : len;
        sum = 8'h00;
        send_byte(8'(len));
        gap();
        for (int unsigned i = 0; i < k; i++) begin
            data = 8'($urandom);
            sum = 8'((int'(sum) + int'(data)) % 256);
            exp_w.push_back({5'(i), data});
            send_byte(data);
            gap();
        end
        if (kind == 1) begin
            step(1'b1, 8'($urandom), 1'b1);
            check_vec($sformatf("rnd%0d_abort", idx), pack(1, 0, 0, 0, 1, 0, 0));
            check_writes($sformatf("rnd%0d_abort_writes", idx));
            return;
        end
        good = ($urandom_range(0, 3) != 0);
        csum = good ? sum : 8'((int'(sum) + int'($urandom_range(1, 255))) % 256);
        send_byte(csum);
        check_vec($sformatf("rnd%0d_flags", idx), pack(0, 0, 0, 0, !good, good, !good));
        check_writes($sformatf("rnd%0d_writes", idx));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset state, checked before any clock edge.
        #1 reset = 1'b1;
        #1 check_vec("reset_state", {1'b1, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b0;

        // v d c | rdy we a wd crst done err
        add(0, 8'h00, 0, 1, 0, 0, 8'h00, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 8'h00, 1, 0, 0);
        add(1, 8'h03, 0, 1, 0, 0, 8'h00, 1, 0, 0);
        add(1, 8'h11, 0, 1, 1, 0, 8'h11, 1, 0, 0);
        add(1, 8'h22, 0, 1, 1, 1, 8'h22, 1, 0, 0);
        add(1, 8'h33, 0, 1, 1, 2, 8'h33, 1, 0, 0);
        add(1, 8'h66, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        add(1, 8'h55, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        add(1, 8'h03, 1, 1, 0, 0, 8'h00, 1, 0, 0);
        add(1, 8'h02, 0, 1, 0, 0, 8'h00, 1, 0, 0);
        add(1, 8'hA0, 0, 1, 1, 0, 8'hA0, 1, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 8'hFF, 0, 1, 0, 0, 8'h00, 1, 0, 0);
        add(1, 8'h05, 0, 1, 1, 1, 8'h05, 1, 0, 0);
        add(1, 8'hA5, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        add(0, 8'h00, 1, 1, 0, 0, 8'h00, 1, 0, 0);
        add(1, 8'h03, 0, 1, 0, 0, 8'h00, 1, 0, 0);
        add(1, 8'h11, 0, 1, 1, 0, 8'h11, 1, 0, 0);
        add(1, 8'h22, 0, 1, 1, 1, 8'h22, 1, 0, 0);
        add(1, 8'h33, 0, 1, 1, 2, 8'h33, 1, 0, 0);
        add(1, 8'h67, 0, 0, 0, 0, 8'h00, 1, 0, 1);
        add(0, 8'h00, 1, 1, 0, 0, 8'h00, 1, 0, 0);
        add(1, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 1);
        add(0, 8'h00, 1, 1, 0, 0, 8'h00, 1, 0, 0);
        add(1, 8'h21, 0, 0, 0, 0, 8'h00, 1, 0, 1);
        add(0, 8'h00, 1, 1, 0, 0, 8'h00, 1, 0, 0);
        add(1, 8'h04, 0, 1, 0, 0, 8'h00, 1, 0, 0);
        add(1, 8'h01, 0, 1, 1, 0, 8'h01, 1, 0, 0);
        add(1, 8'h02, 0, 1, 1, 1, 8'h02, 1, 0, 0);
        add(1, 8'h09, 1, 1, 0, 0, 8'h00, 1, 0, 0);
        add(1, 8'h01, 0, 1, 0, 0, 8'h00, 1, 0, 0);
        add(1, 8'h7E, 0, 1, 1, 0, 8'h7E, 1, 0, 0);
        add(1, 8'h7E, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        add(0, 8'h00, 1, 1, 0, 0, 8'h00, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].c);
            check_vec($sformatf("vec%0d", i),
                      pack(tbl[i].rdy, tbl[i].we, tbl[i].a, tbl[i].wd,
                           tbl[i].crst, tbl[i].dn, tbl[i].er));
        end

        // Full-depth frame: 32 bytes of 0xFF at addresses 0..31, CSUM 0xE0.
        begin_frame();
        send_byte(8'h20);
        for (int i = 0; i < 32; i++) begin
            exp_w.push_back({5'(i), 8'hFF});
            send_byte(8'hFF);
        end
        send_byte(8'hE0);
        check_vec("full_done", pack(0, 0, 0, 0, 0, 1, 0));
        check_writes("full_writes");

        // Reset while done: cpu_reset must rise without a clock edge.
        #2 reset = 1'b1;
        #1 check_vec("async_reset", pack(1, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        reset = 1'b0;

        // Idle source leaves WAIT_LEN untouched with no writes.
        begin_frame();
        repeat (10) step(1'b0, 8'($urandom), 1'b0);
        check_vec("idle", pack(1, 0, 0, 0, 1, 0, 0));
        check_writes("idle_writes");

        for (int unsigned f = 0; f < 40; f++) random_frame(f);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader; the writer side of the CPU's 32x8 instruction/data memory.
- Receives a framed byte stream over a valid/ready handshake and writes bytes into memory from address 0 upward.
- Verifies a modulo-256 checksum over the received data bytes.
- Holds the CPU in reset until a load completes with a matching checksum.

Parameters:
- DEPTH, 32, number of memory bytes; maximum accepted frame length.
- ADDR_W, 5, memory address width (log2 DEPTH).
- DATA_W, 8, byte width; sum and checksum width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous abort/restart request
- in_valid  in  1  source presents a byte
- in_data  in  DATA_W  byte from source
- in_ready  out  1  loader can accept a byte
- mem_we  out  1  memory write strobe, one cycle per byte
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- cpu_reset  out  1  holds the CPU in reset while high
- done  out  1  load complete, checksum good
- error  out  1  bad length or checksum mismatch

Behaviour:
- Frame format: LEN byte (1..DEPTH), then LEN data bytes, then CSUM byte. CSUM = sum of data bytes mod 256.
- A byte is accepted when in_valid & in_ready are both high on a clk edge. in_data is sampled only on accept.
- Reset values: state=WAIT_LEN, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0, count=0, sum=0.
- All outputs are registered. in_ready is decoded directly from state.
- State WAIT_LEN (in_ready=1):
  - On accept with LEN==0 or LEN>DEPTH -> ERR.
  - Otherwise latch LEN, set count=0 and sum=0 -> LOAD.
- State LOAD (in_ready=1):
  - On accept: next cycle mem_we=1, mem_addr=count, mem_wdata=byte.
  - sum <= sum+byte, wrapping at 8 bits.
  - count <= count+1.
  - When the accepted byte is byte number LEN -> WAIT_CSUM.
  - mem_we is low on any cycle that follows a cycle with no accept.
- State WAIT_CSUM (in_ready=1):
  - On accept, compare the byte with sum. Equal -> DONE; unequal -> ERR.
  - The CSUM byte is never written to memory.
- State DONE (in_ready=0): cpu_reset=0, done=1. Stays until clear.
- State ERR (in_ready=0): cpu_reset=1, error=1. Stays until clear.
- Accept-to-flag latency: done or error rises on the first edge after the final accept, i.e. visible 1 cycle after the handshake.
- clear, in any state:
  - Next state is WAIT_LEN; count, sum, done, error are zeroed; cpu_reset=1.
  - A byte presented in the same cycle as clear is discarded, with no memory write.
  - Any pending mem_we for that cycle is suppressed.
  - clear has priority over every other transition.
- Full boundary: LEN==DEPTH writes addresses 0..DEPTH-1 with no address wrap. count never exceeds LEN.
- Idle source: in_valid=0 indefinitely leaves the state unchanged, with no writes.
- reset mid-frame: immediate return to reset values. Memory already written is untouched. cpu_reset rises asynchronously.

Optional Feature:
- Macro: LOADER_ZERO_FILL_EN.
- With the macro defined:
  - A successful checksum enters state FILL instead of DONE.
  - FILL holds in_ready=0 and writes 0x00 to addresses LEN..DEPTH-1, one per cycle (mem_we=1), then goes to DONE.
  - With LEN==DEPTH, FILL is skipped and the block goes straight to DONE.
  - clear during FILL aborts to WAIT_LEN.
  - A checksum mismatch goes to ERR with no fill.
- Without the macro: no FILL state; addresses at or above LEN keep their prior contents.

Test Plan:
- Stream 0x03, 0x11, 0x22, 0x33, 0x66 with in_valid held high -> three writes (0,0x11), (1,0x22), (2,0x33). done=1 and cpu_reset=0 one cycle after the 0x66 accept. error=0.
- Same frame with CSUM 0x67 -> no change to the three writes. error=1, cpu_reset=1, done=0, in_ready=0.
- LEN byte 0x00, then separately 0x21 -> error=1 immediately after the LEN accept; mem_we never asserted.
- LEN 0x20 with 32 bytes of 0xFF and CSUM 0xE0 -> writes addresses 0..31 with no wrap; done=1.
- Frame 0x02, 0xA0, gap of 5 cycles with in_valid=0, 0x05, 0xA5 -> mem_we low during the gap; done=1.
- Assert clear after the second data byte of a LEN=4 frame, then send a full valid frame 0x01, 0x7E, 0x7E -> first frame abandoned; the second frame sets done=1. With LOADER_ZERO_FILL_EN defined, addresses 1..31 are written with 0x00 before done rises, 31 fill cycles.
